// File: rtl/d_reg_pkg.sv
// Shared constants and helpers for the d_reg_pipe register pipeline.
package d_reg_pkg;

    // Default geometry and reset contents of the pipeline.
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_RESET_VAL = 0;

    // Bits needed to count 0..depth valid stages (never less than one bit).
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/d_reg_stage.sv
// One pipeline stage: valid bit, data register and take/advance decision.
module d_reg_stage
    import d_reg_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             CLK,
    input  logic             SYNC_RESET_N,
    input  logic             FLUSH,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             down_ready,
    output logic             stage_valid,
    output logic [WIDTH-1:0] stage_data,
    output logic             stage_take
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // The stage can take a new word when it is empty or its word is leaving.
    always_comb begin
        stage_take = !valid_reg || down_ready;
    end

    // Valid/data update; data only loads when a real word arrives so
    // invalid slots never toggle the data register.
    always_ff @(posedge CLK) begin
        if (!SYNC_RESET_N) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_VAL;
        end else if (FLUSH) begin
            valid_reg <= 1'b0;
        end else if (stage_take) begin
            valid_reg <= prev_valid;
            if (prev_valid) begin
                data_reg <= prev_data;
            end
        end
    end

    assign stage_valid = valid_reg;
    assign stage_data  = data_reg;

endmodule

// File: rtl/d_reg_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake,
// bubble collapse, synchronous flush and a registered occupancy count.
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter int                 DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic                            CLK,
    input  logic                            SYNC_RESET_N,
    input  logic                            FLUSH,
    input  logic                            IN_VALID,
    output logic                            IN_READY,
    input  logic [WIDTH-1:0]                D,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [WIDTH-1:0]                Q,
    output logic [occ_width(DEPTH)-1:0]     OCCUPANCY
);

    localparam int OCC_W = occ_width(DEPTH);

    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    // Stage chain: each stage looks at its upstream neighbour for data and
    // at its downstream neighbour's take signal for permission to advance.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
            logic             stage_valid;
            logic [WIDTH-1:0] stage_data;
            logic             stage_take;
            logic             prev_valid;
            logic [WIDTH-1:0] prev_data;
            logic             down_ready;

            if (gi == 0) begin : g_first
                assign prev_valid = IN_VALID;
                assign prev_data  = D;
            end else begin : g_mid
                assign prev_valid = g_stage[gi-1].stage_valid;
                assign prev_data  = g_stage[gi-1].stage_data;
            end

            if (gi == DEPTH - 1) begin : g_last
                assign down_ready = OUT_READY;
            end else begin : g_inner
                assign down_ready = g_stage[gi+1].stage_take;
            end

            d_reg_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .CLK          (CLK),
                .SYNC_RESET_N (SYNC_RESET_N),
                .FLUSH        (FLUSH),
                .prev_valid   (prev_valid),
                .prev_data    (prev_data),
                .down_ready   (down_ready),
                .stage_valid  (stage_valid),
                .stage_data   (stage_data),
                .stage_take   (stage_take)
            );
        end
    endgenerate

    // Handshake outputs; FLUSH hides the output word and refuses input.
    always_comb begin
        IN_READY  = g_stage[0].stage_take && !FLUSH;
        OUT_VALID = g_stage[DEPTH-1].stage_valid && !FLUSH;
        Q         = g_stage[DEPTH-1].stage_data;
        in_xfer   = IN_VALID && IN_READY;
        out_xfer  = OUT_VALID && OUT_READY;
    end

    // Occupancy next value from the two transfer strobes.
    always_comb begin
        occ_next = occ_reg;
        if (FLUSH) begin
            occ_next = '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_next = occ_reg + OCC_W'(1);
                2'b01:   occ_next = occ_reg - OCC_W'(1);
                default: occ_next = occ_reg;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK) begin
        if (!SYNC_RESET_N) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign OCCUPANCY = occ_reg;

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed bench for d_reg_pipe: vector table plus hand sequences for
// bubble collapse, flush and mid-stream reset.
module tb_d_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic       CLK = 1'b0;
    logic       SYNC_RESET_N = 1'b0;
    logic       FLUSH = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] D = 8'h00;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [7:0] Q;
    logic [2:0] OCCUPANCY;

    int total = 0;
    int bad   = 0;

    d_reg_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .CLK          (CLK),
        .SYNC_RESET_N (SYNC_RESET_N),
        .FLUSH        (FLUSH),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .D            (D),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .Q            (Q),
        .OCCUPANCY    (OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       chk;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_q;
        logic [2:0] e_occ;
    } vec_t;

    vec_t vq[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic rst_n, input logic iv, input logic [7:0] d,
                         input logic ordy, input logic fl);
        @(negedge CLK);
        SYNC_RESET_N = rst_n;
        IN_VALID     = iv;
        D            = d;
        OUT_READY    = ordy;
        FLUSH        = fl;
        #1;
    endtask

    task automatic chk4(input string tag, input logic e_ir, input logic e_ov,
                        input logic [7:0] e_q, input logic [2:0] e_occ);
        cmp({tag, ".in_ready"},  {31'd0, IN_READY},  {31'd0, e_ir});
        cmp({tag, ".out_valid"}, {31'd0, OUT_VALID}, {31'd0, e_ov});
        cmp({tag, ".q"},         {24'd0, Q},         {24'd0, e_q});
        cmp({tag, ".occupancy"}, {29'd0, OCCUPANCY}, {29'd0, e_occ});
    endtask

    task automatic push_vec(input logic rst_n, input logic iv, input logic [7:0] d,
                            input logic ordy, input logic fl, input logic c,
                            input logic e_ir, input logic e_ov, input logic [7:0] e_q,
                            input logic [2:0] e_occ);
        vec_t v;
        v.rst_n = rst_n; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.chk = c; v.e_ir = e_ir; v.e_ov = e_ov; v.e_q = e_q; v.e_occ = e_occ;
        vq.push_back(v);
    endtask

    initial begin
        // Reset: two edges with SYNC_RESET_N low.
        push_vec(0, 0, 8'h00, 0, 0, 0, 1, 0, RV,    3'd0);
        push_vec(0, 0, 8'h00, 0, 0, 1, 1, 0, RV,    3'd0);
        // Latency/throughput: 01..08 back-to-back with OUT_READY high.
        push_vec(1, 1, 8'h01, 1, 0, 1, 1, 0, RV,    3'd0);
        push_vec(1, 1, 8'h02, 1, 0, 1, 1, 0, RV,    3'd1);
        push_vec(1, 1, 8'h03, 1, 0, 1, 1, 0, RV,    3'd2);
        push_vec(1, 1, 8'h04, 1, 0, 1, 1, 0, RV,    3'd3);
        push_vec(1, 1, 8'h05, 1, 0, 1, 1, 1, 8'h01, 3'd4);
        push_vec(1, 1, 8'h06, 1, 0, 1, 1, 1, 8'h02, 3'd4);
        push_vec(1, 1, 8'h07, 1, 0, 1, 1, 1, 8'h03, 3'd4);
        push_vec(1, 1, 8'h08, 1, 0, 1, 1, 1, 8'h04, 3'd4);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h05, 3'd4);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h06, 3'd3);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h07, 3'd2);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h08, 3'd1);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h08, 3'd0);
        // Backpressure: six words offered with OUT_READY low.
        push_vec(1, 1, 8'h31, 0, 0, 1, 1, 0, 8'h08, 3'd0);
        push_vec(1, 1, 8'h32, 0, 0, 1, 1, 0, 8'h08, 3'd1);
        push_vec(1, 1, 8'h33, 0, 0, 1, 1, 0, 8'h08, 3'd2);
        push_vec(1, 1, 8'h34, 0, 0, 1, 1, 0, 8'h08, 3'd3);
        push_vec(1, 1, 8'h35, 0, 0, 1, 0, 1, 8'h31, 3'd4);
        push_vec(1, 1, 8'h35, 0, 0, 1, 0, 1, 8'h31, 3'd4);
        // Release: full pipe shifts while accepting the remaining two.
        push_vec(1, 1, 8'h35, 1, 0, 1, 1, 1, 8'h31, 3'd4);
        push_vec(1, 1, 8'h36, 1, 0, 1, 1, 1, 8'h32, 3'd4);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h33, 3'd4);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h34, 3'd3);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h35, 3'd2);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h36, 3'd1);
        push_vec(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h36, 3'd0);

        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].iv, vq[i].d, vq[i].ordy, vq[i].fl);
            if (vq[i].chk) begin
                chk4($sformatf("vec%0d", i), vq[i].e_ir, vq[i].e_ov, vq[i].e_q, vq[i].e_occ);
            end
            $display("vec %0d: iv=%0b d=%02h ordy=%0b -> ir=%0b ov=%0b q=%02h occ=%0d",
                     i, vq[i].iv, vq[i].d, vq[i].ordy, IN_READY, OUT_VALID, Q, OCCUPANCY);
        end

        // Bubble collapse: 11, two idle cycles, 22, all with OUT_READY low.
        drive(1, 1, 8'h11, 0, 0); chk4("bub_push1", 1, 0, 8'h36, 3'd0);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 1, 8'h22, 0, 0); chk4("bub_push2", 1, 0, 8'h36, 3'd1);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0); chk4("bub_held", 1, 1, 8'h11, 3'd2);
        drive(1, 0, 8'h00, 0, 0); chk4("bub_stable", 1, 1, 8'h11, 3'd2);
        drive(1, 0, 8'h00, 1, 0); chk4("bub_out1", 1, 1, 8'h11, 3'd2);
        drive(1, 0, 8'h00, 1, 0); chk4("bub_out2", 1, 1, 8'h22, 3'd1);
        drive(1, 0, 8'h00, 0, 0); chk4("bub_empty", 1, 0, 8'h22, 3'd0);
        $display("seq bubble done: bad=%0d", bad);

        // Flush with three words held and a word offered.
        drive(1, 1, 8'h41, 0, 0);
        drive(1, 1, 8'h42, 0, 0);
        drive(1, 1, 8'h43, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0); chk4("fl_before", 1, 1, 8'h41, 3'd3);
        drive(1, 1, 8'h44, 0, 1); chk4("fl_during", 0, 0, 8'h41, 3'd3);
        drive(1, 0, 8'h00, 1, 0); chk4("fl_after", 1, 0, 8'h41, 3'd0);
        drive(1, 0, 8'h00, 0, 0); chk4("fl_after2", 1, 0, 8'h41, 3'd0);
        $display("seq flush done: bad=%0d", bad);

        // Reset mid-stream with a full pipe, FLUSH and OUT_READY high.
        drive(1, 1, 8'h51, 0, 0);
        drive(1, 1, 8'h52, 0, 0);
        drive(1, 1, 8'h53, 0, 0);
        drive(1, 1, 8'h54, 0, 0);
        drive(1, 1, 8'h55, 0, 0); chk4("rst_full", 0, 1, 8'h51, 3'd4);
        drive(0, 1, 8'h55, 1, 1);
        drive(1, 0, 8'h00, 0, 0); chk4("rst_after", 1, 0, RV, 3'd0);
        drive(1, 0, 8'h00, 1, 0); chk4("rst_after2", 1, 0, RV, 3'd0);
        $display("seq reset done: bad=%0d", bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
